// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer slice.
//   - PC_W                : program counter width
//   - DEFAULT_STACK_DEPTH : default number of return-stack entries
//   - STACK_MAX           : largest supported return-stack depth
//   - seq_state_e         : sequencer FSM state encoding
//   - pc_inc()            : modulo-256 PC increment
package pc_seq_pkg;

    localparam int PC_W                = 8;
    localparam int DEFAULT_STACK_DEPTH = 4;
    localparam int STACK_MAX           = 8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_ERROR = 2'd2
    } seq_state_e;

    // Natural 8-bit overflow gives the FF -> 00 wrap with no flag.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + 8'd1;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Return-address stack for the PC sequencer.
// Ports:
//   CLK      - clock, rising edge
//   RESET_N  - asynchronous active-low reset (clears the pointer only)
//   push_i   - push data_i (ignored when full)
//   pop_i    - pop top entry (ignored when empty)
//   data_i   - return address to push
//   data_o   - current top-of-stack entry (valid when !empty_o)
//   full_o   - stack holds DEPTH entries
//   empty_o  - stack holds no entries
module pc_return_stack
    import pc_seq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_STACK_DEPTH
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] data_i,
    output logic [PC_W-1:0] data_o,
    output logic            full_o,
    output logic            empty_o
);

    // Storage is sized for the largest legal depth; DEPTH only moves the
    // full threshold, so indexing stays a fixed 3-bit field.
    logic [PC_W-1:0] mem_q [STACK_MAX];
    logic [3:0]      sp_q;
    logic [3:0]      sp_d;
    logic [2:0]      wr_idx;
    logic [2:0]      rd_idx;

    assign wr_idx  = sp_q[2:0];
    // With sp_q == 8 the low bits are 0, so the minus-one wraps to entry 7.
    assign rd_idx  = sp_q[2:0] - 3'd1;
    assign full_o  = (sp_q == 4'(DEPTH));
    assign empty_o = (sp_q == 4'd0);
    assign data_o  = mem_q[rd_idx];

    always_comb begin
        sp_d = sp_q;
        if (push_i && !full_o) begin
            sp_d = sp_q + 4'd1;
        end else if (pop_i && !empty_o) begin
            sp_d = sp_q - 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sp_q <= 4'd0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry contents are not reset: a reset pointer makes them unreachable.
    always_ff @(posedge CLK) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer with return stack and RUN/HALT/ERROR control.
// Ports:
//   CLK, RESET_N  - clock (rising edge) and asynchronous active-low reset
//   STALL         - freeze PC, stack and FSM for this cycle
//   JUMP          - unconditional load of TARGET
//   BRANCH, COND  - load TARGET when COND is high
//   CALL          - push PC+1, load TARGET
//   RET           - pop top of stack into PC
//   TARGET        - jump/branch/call destination
//   HALT_REQ      - enter HALT from RUN
//   RESUME        - leave HALT
//   PC            - registered program counter
//   HALTED        - high in HALT or ERROR
//   STACK_ERR     - sticky overflow/underflow flag, cleared only by reset
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              STACK_DEPTH = DEFAULT_STACK_DEPTH,
    parameter logic [PC_W-1:0] RESET_VEC   = 8'h00
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            STALL,
    input  logic            JUMP,
    input  logic            BRANCH,
    input  logic            COND,
    input  logic            CALL,
    input  logic            RET,
    input  logic [PC_W-1:0] TARGET,
    input  logic            HALT_REQ,
    input  logic            RESUME,
    output logic [PC_W-1:0] PC,
    output logic            HALTED,
    output logic            STACK_ERR
);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            err_q, err_d;
    logic            push, pop;
    logic [PC_W-1:0] stk_top;
    logic            stk_full, stk_empty;

    pc_return_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_inc(pc_q)),
        .data_o  (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        // STALL overrides everything, so all decisions sit under !STALL.
        if (!STALL) begin
            unique case (state_q)
                ST_RUN: begin
                    if (HALT_REQ) begin
                        state_d = ST_HALT;
                    end else if (RET) begin
                        if (stk_empty) begin
                            err_d   = 1'b1;
                            state_d = ST_ERROR;
                        end else begin
                            pop  = 1'b1;
                            pc_d = stk_top;
                        end
                    end else if (CALL) begin
                        if (stk_full) begin
                            err_d   = 1'b1;
                            state_d = ST_ERROR;
                        end else begin
                            push = 1'b1;
                            pc_d = TARGET;
                        end
                    end else if (JUMP || (BRANCH && COND)) begin
                        pc_d = TARGET;
                    end else begin
                        pc_d = pc_inc(pc_q);
                    end
                end
                ST_HALT: begin
                    // A concurrent HALT_REQ keeps us parked.
                    if (RESUME && !HALT_REQ) begin
                        state_d = ST_RUN;
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_ERROR;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VEC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    assign PC        = pc_q;
    assign HALTED    = (state_q != ST_RUN);
    assign STACK_ERR = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       STALL = 1'b0, JUMP = 1'b0, BRANCH = 1'b0, COND = 1'b0;
    logic       CALL = 1'b0, RET = 1'b0, HALT_REQ = 1'b0, RESUME = 1'b0;
    logic [7:0] TARGET = 8'h00;
    logic [7:0] PC;
    logic       HALTED, STACK_ERR;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Behavioural model: PC as an integer, return stack as a queue, mode flags.
    int m_pc  = 0;
    int m_stk[$];
    bit m_halt = 1'b0;
    bit m_err  = 1'b0;

    pc_sequencer #(
        .STACK_DEPTH (DEPTH),
        .RESET_VEC   (8'h00)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .STALL     (STALL),
        .JUMP      (JUMP),
        .BRANCH    (BRANCH),
        .COND      (COND),
        .CALL      (CALL),
        .RET       (RET),
        .TARGET    (TARGET),
        .HALT_REQ  (HALT_REQ),
        .RESUME    (RESUME),
        .PC        (PC),
        .HALTED    (HALTED),
        .STACK_ERR (STACK_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = 0;
        m_stk  = {};
        m_halt = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        if (!RESET_N) begin
            model_reset();
        end else if (!STALL) begin
            if (m_err) begin
                // stuck until reset
            end else if (m_halt) begin
                if (RESUME && !HALT_REQ) m_halt = 1'b0;
            end else if (HALT_REQ) begin
                m_halt = 1'b1;
            end else if (RET) begin
                if (m_stk.size() == 0) m_err = 1'b1;
                else m_pc = m_stk.pop_back();
            end else if (CALL) begin
                if (m_stk.size() == DEPTH) m_err = 1'b1;
                else begin
                    m_stk.push_back((m_pc + 1) % 256);
                    m_pc = int'(TARGET);
                end
            end else if (JUMP || (BRANCH && COND)) begin
                m_pc = int'(TARGET);
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
        end
    endtask

    // One clock: model follows the edge, inputs may change 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic idle();
        STALL = 0; JUMP = 0; BRANCH = 0; COND = 0; CALL = 0; RET = 0;
        HALT_REQ = 0; RESUME = 0; TARGET = 8'h00;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        model_reset();
        #1;
        check("rst_pc_immediate", int'(PC), 0);
        check("rst_halted", int'(HALTED), 0);
        check("rst_stack_err", int'(STACK_ERR), 0);
        tick();
        @(negedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    task automatic jump_to(input logic [7:0] t);
        idle();
        JUMP = 1; TARGET = t;
        tick();
        idle();
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("cyc_pc", int'(PC), m_pc);
            check("cyc_halted", int'(HALTED), int'(m_halt || m_err));
            check("cyc_stack_err", int'(STACK_ERR), int'(m_err));
        end
    end

    initial begin
        idle();
        #2;
        chk_en = 1'b1;
        do_reset();

        // Free-running count with wrap.
        for (int i = 0; i < 300; i++) tick();
        check("count300_pc", int'(PC), 8'h2C);
        check("count300_err", int'(STACK_ERR), 0);

        // Call / return.
        jump_to(8'h10);
        check("jump10", int'(PC), 8'h10);
        CALL = 1; TARGET = 8'h40; tick(); idle();
        check("call40", int'(PC), 8'h40);
        tick(); check("inc41", int'(PC), 8'h41);
        tick(); check("inc42", int'(PC), 8'h42);
        tick(); check("inc43", int'(PC), 8'h43);
        RET = 1; tick(); idle();
        check("ret11", int'(PC), 8'h11);

        // Branch / jump priority.
        jump_to(8'h20);
        BRANCH = 1; COND = 0; TARGET = 8'h55; tick(); idle();
        check("branch_nt", int'(PC), 8'h21);
        BRANCH = 1; COND = 1; TARGET = 8'h80; tick(); idle();
        check("branch_t", int'(PC), 8'h80);
        JUMP = 1; BRANCH = 1; COND = 1; TARGET = 8'h90; tick(); idle();
        check("jump_branch", int'(PC), 8'h90);
        CALL = 1; TARGET = 8'h30; tick(); idle();
        check("call30", int'(PC), 8'h30);
        CALL = 1; RET = 1; TARGET = 8'h77; tick(); idle();
        check("call_ret_ret_wins", int'(PC), 8'h91);

        // Nested calls, LIFO order, overflow.
        CALL = 1; TARGET = 8'hA0; tick();
        TARGET = 8'hB0; tick();
        TARGET = 8'hC0; tick();
        TARGET = 8'hD0; tick(); idle();
        check("nest4_pc", int'(PC), 8'hD0);
        RET = 1; tick(); idle();
        check("nest_ret_lifo", int'(PC), 8'hC1);
        CALL = 1; TARGET = 8'hD0; tick(); idle();
        check("recall_pc", int'(PC), 8'hD0);
        CALL = 1; TARGET = 8'hE0; tick(); idle();
        check("ovf_pc", int'(PC), 8'hD0);
        check("ovf_err", int'(STACK_ERR), 1);
        check("ovf_halted", int'(HALTED), 1);
        RESUME = 1; tick(); idle();
        check("err_resume_halted", int'(HALTED), 1);
        check("err_resume_pc", int'(PC), 8'hD0);
        do_reset();
        check("after_rst_pc", int'(PC), 0);

        // Halt / resume / stall.
        jump_to(8'h05);
        HALT_REQ = 1; JUMP = 1; TARGET = 8'h99; tick(); idle();
        check("halt_pc", int'(PC), 8'h05);
        check("halt_flag", int'(HALTED), 1);
        JUMP = 1; TARGET = 8'h99;
        for (int i = 0; i < 10; i++) tick();
        idle();
        check("halt10_pc", int'(PC), 8'h05);
        RESUME = 1; HALT_REQ = 1; tick(); idle();
        check("resume_and_halt", int'(HALTED), 1);
        RESUME = 1; tick(); idle();
        check("resume_halted", int'(HALTED), 0);
        check("resume_pc", int'(PC), 8'h05);
        tick();
        check("resume_next", int'(PC), 8'h06);
        STALL = 1; JUMP = 1; HALT_REQ = 1; TARGET = 8'h77;
        for (int i = 0; i < 3; i++) tick();
        idle();
        check("stall_pc", int'(PC), 8'h06);
        check("stall_halted", int'(HALTED), 0);
        tick();
        check("after_stall", int'(PC), 8'h07);

        // Underflow, then reset during a CALL.
        RET = 1; tick(); idle();
        check("unf_err", int'(STACK_ERR), 1);
        check("unf_pc", int'(PC), 8'h07);
        check("unf_halted", int'(HALTED), 1);
        do_reset();
        jump_to(8'h12);
        CALL = 1; TARGET = 8'h33;
        @(negedge CLK);
        #1;
        RESET_N = 1'b0;
        model_reset();
        tick();
        idle();
        @(negedge CLK);
        #1;
        RESET_N = 1'b1;
        check("rst_mid_call_pc", int'(PC), 0);
        RET = 1; tick(); idle();
        check("rst_mid_call_empty", int'(STACK_ERR), 1);

        // Wrap from FF.
        do_reset();
        jump_to(8'hFF);
        tick();
        check("wrap_ff", int'(PC), 8'h00);
        check("wrap_no_err", int'(STACK_ERR), 0);

        tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter STACK_DEPTH, default 4, SHALL set the number of return-stack entries (legal 2..8).
REQ-002 Parameter RESET_VEC, default 8'h00, SHALL set the PC value loaded on reset.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RESET_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 STALL  input  1  SHALL, when high, freeze PC, stack and FSM for that cycle.
REQ-006 JUMP  input  1  SHALL request an unconditional load of TARGET.
REQ-007 BRANCH  input  1  SHALL request a load of TARGET qualified by COND.
REQ-008 COND  input  1  SHALL be the branch condition, sampled only with BRANCH.
REQ-009 CALL  input  1  SHALL request push of PC+1 and load of TARGET.
REQ-010 RET  input  1  SHALL request pop of the top stack entry into PC.
REQ-011 TARGET  input  8  SHALL be the jump/branch/call destination.
REQ-012 HALT_REQ  input  1  SHALL request entry to HALT.
REQ-013 RESUME  input  1  SHALL request exit from HALT.
REQ-014 PC  output  8  SHALL be the current program counter (registered).
REQ-015 HALTED  output  1  SHALL be high while the FSM is in HALT or ERROR.
REQ-016 STACK_ERR  output  1  SHALL be a sticky flag for stack overflow/underflow.

Function
REQ-017 FSM states SHALL be RUN, HALT, ERROR; reset state RUN.
REQ-018 In RUN with STALL low, next PC SHALL be chosen by fixed priority: RET > CALL > JUMP > (BRANCH & COND) > PC+1.
REQ-019 BRANCH with COND low SHALL behave as PC+1.
REQ-020 PC+1 SHALL wrap 8'hFF -> 8'h00 with no flag.
REQ-021 CALL SHALL push (PC+1) mod 256 and load TARGET in the same cycle; latency to new PC one cycle.
REQ-022 RET SHALL load the popped value into PC in the same cycle; latency one cycle.
REQ-023 CALL with stack full SHALL leave PC and stack unchanged, set STACK_ERR, and go to ERROR.
REQ-024 RET with stack empty SHALL leave PC unchanged, set STACK_ERR, and go to ERROR.
REQ-025 Simultaneous CALL and RET SHALL execute RET only (priority), CALL ignored.
REQ-026 HALT_REQ in RUN with STALL low SHALL go to HALT, PC unchanged that cycle, all other requests ignored.
REQ-027 STALL high SHALL take precedence over HALT_REQ, RESUME and all PC requests.
REQ-028 In HALT, PC and stack SHALL hold; RESUME with STALL low SHALL return to RUN next cycle, resuming with PC+1 on the following cycle.
REQ-029 HALT_REQ and RESUME both high in HALT SHALL stay in HALT.
REQ-030 ERROR SHALL be exited only by reset; RESUME SHALL have no effect.
REQ-031 Requests in HALT or ERROR (other than RESUME) SHALL be ignored.

Reset
REQ-032 RESET_N low SHALL immediately set PC=RESET_VEC, stack pointer=0 (empty), STACK_ERR=0, FSM=RUN, HALTED=0.
REQ-033 Reset asserted mid-CALL/RET SHALL discard the operation; no partial push/pop SHALL survive.
REQ-034 Stack entry contents need not be reset; only the pointer SHALL be.

Structure
REQ-035 FSM state encodings and the default STACK_DEPTH SHALL live in shared package pc_seq_pkg.
REQ-036 The return stack SHALL be a sub-module pc_return_stack (push, pop, data in/out, full, empty) on CLK/RESET_N.
REQ-037 PC register SHALL remain a plain 8-bit register inside pc_sequencer; no combinational path from inputs to PC.

Verification
REQ-038 Reset release, no requests, 300 cycles -> PC 00,01,...,FF,00,01..., STACK_ERR=0.
REQ-039 PC=10, CALL TARGET=40; then 3 increments; RET -> PC 40,41,42,43,11.
REQ-040 PC=20: BRANCH COND=0 -> 21; BRANCH COND=1 TARGET=80 -> 80; JUMP+BRANCH TARGET=90 -> 90.
REQ-041 Four nested CALLs then fifth CALL -> PC unchanged, STACK_ERR=1, HALTED=1; RESUME ignored; RESET_N low -> PC=00, HALTED=0.
REQ-042 PC=05, HALT_REQ -> PC holds 05, HALTED=1 for 10 cycles; RESUME -> HALTED=0, next PC 06; STALL held 3 cycles -> PC frozen.
REQ-043 Empty stack, RET -> STACK_ERR=1, ERROR; RESET_N asserted during CALL cycle -> PC=00, stack empty.
